// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: BCD digit type and increment helper.
package freq_meter_pkg;

    localparam int unsigned DIGITS_DEFAULT = 6;
    localparam logic [3:0]  BCD_NINE       = 4'd9;

    typedef logic [3:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d == BCD_NINE) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One BCD decade of the running edge count; wraps 9 -> 0, holds while saturated.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       hold,
    output bcd_digit_t q,
    output logic       is_nine
);

    bcd_digit_t q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (inc && !hold) begin
            q_q <= bcd_inc(q_q);
        end
    end

    assign q       = q_q;
    assign is_nine = (q_q == BCD_NINE);

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over back-to-back gate windows and latches the
// result as packed BCD digits with a sticky overflow flag.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned DIGITS      = DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  meas_valid,
    output logic                  gate_active
);

    localparam int unsigned      CNT_W     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    logic             sync1_q, sync2_q, dly_q;
    logic [2:0]       fill_q;
    logic             strobe;
    logic [CNT_W-1:0] gate_cnt_q;
    logic             terminal;
    logic             gate_active_q;

    logic [DIGITS-1:0]   is_nine;
    logic [DIGITS-1:0]   inc;
    logic [4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0] count_next;
    logic                all_nine;
    logic                sat_hit;
    logic                ovf_q;

    logic [4*DIGITS-1:0] bcd_out_q;
    logic                overflow_q;
    logic                meas_valid_q;

    // fill_q marks when sync2/dly hold real samples, so a level already high
    // at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            fill_q  <= '0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            fill_q  <= {fill_q[1:0], 1'b1};
        end
    end

    assign strobe = sync2_q & ~dly_q & fill_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_q    <= '0;
            gate_active_q <= 1'b0;
        end else begin
            gate_active_q <= 1'b1;
            gate_cnt_q    <= terminal ? '0 : gate_cnt_q + CNT_W'(1);
        end
    end

    assign terminal = (gate_cnt_q == GATE_LAST);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .rst     (rst),
            .clr     (terminal),
            .inc     (inc[k]),
            .hold    (all_nine),
            .q       (count[4*k +: 4]),
            .is_nine (is_nine[k])
        );
    end

    assign all_nine = &is_nine;
    assign sat_hit  = strobe & all_nine;

    // Carry chain plus the post-strobe value that the terminal cycle latches.
    always_comb begin
        logic run;
        run        = 1'b1;
        inc        = '0;
        count_next = count;
        for (int k = 0; k < DIGITS; k++) begin
            inc[k] = strobe & run;
            if (inc[k] && !all_nine) begin
                count_next[4*k +: 4] = bcd_inc(count[4*k +: 4]);
            end
            run = run & is_nine[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q        <= 1'b0;
            bcd_out_q    <= '0;
            overflow_q   <= 1'b0;
            meas_valid_q <= 1'b0;
        end else begin
            meas_valid_q <= terminal;
            if (terminal) begin
                bcd_out_q  <= count_next;
                overflow_q <= ovf_q | sat_hit;
                ovf_q      <= 1'b0;
            end else if (sat_hit) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bcd_out     = bcd_out_q;
    assign overflow    = overflow_q;
    assign meas_valid  = meas_valid_q;
    assign gate_active = gate_active_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: three instances (1000/6, 1000/2, 10000/6 digits)
// share clock, reset and stimulus; expectations are hand-computed edge counts.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic [23:0] bcd_a, bcd_c;
    logic [7:0]  bcd_b;
    logic        ovf_a, ovf_b, ovf_c;
    logic        mv_a, mv_b, mv_c;
    logic        ga_a, ga_b, ga_c;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(1000), .DIGITS(6)) u_dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .bcd_out(bcd_a),
        .overflow(ovf_a), .meas_valid(mv_a), .gate_active(ga_a)
    );

    freq_meter #(.GATE_CYCLES(1000), .DIGITS(2)) u_dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .bcd_out(bcd_b),
        .overflow(ovf_b), .meas_valid(mv_b), .gate_active(ga_b)
    );

    freq_meter #(.GATE_CYCLES(10000), .DIGITS(6)) u_dut_c (
        .clk(clk), .rst(rst), .sig_in(sig_in), .bcd_out(bcd_c),
        .overflow(ovf_c), .meas_valid(mv_c), .gate_active(ga_c)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus generator: sig_in changes 1 time unit after each rising clk edge.
    int cyc     = 0;
    int t0      = 0;
    bit wave_on = 1'b0;
    bit level   = 1'b1;
    int wave_hi = 5;
    int wave_lo = 5;

    initial begin
        sig_in = level;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (wave_on) sig_in = ((cyc - t0) % (wave_hi + wave_lo)) < wave_hi;
            else         sig_in = level;
        end
    end

    bit bad_nibble = 1'b0;

    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (bcd_a[4*k +: 4] > 4'd9 || bcd_c[4*k +: 4] > 4'd9 ||
                u_dut_c.count[4*k +: 4] > 4'd9) bad_nibble = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (bcd_b[4*k +: 4] > 4'd9) bad_nibble = 1'b1;
        end
    end

    task automatic wait_valid(input int sel, input int bound, output int at_cyc);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < bound) begin
            @(negedge clk);
            n++;
            hit = (sel == 0) ? mv_a : (sel == 1) ? mv_b : mv_c;
        end
        check_eq($sformatf("meas_valid_arrived_sel%0d", sel), hit, 1);
        at_cyc = cyc;
    endtask

    int c_rel, c, c_prev;
    int w1, w2, w3;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_bcd_out", bcd_a, 0);
        check_eq("rst_overflow", ovf_a, 0);
        check_eq("rst_meas_valid", mv_a, 0);
        check_eq("rst_gate_active", ga_a, 0);

        // sig_in held high from reset: no edge, count 0
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        c_rel = cyc;
        @(negedge clk);
        check_eq("gate_active_rise", ga_a, 1);
        wait_valid(0, 1100, c);
        check_eq("first_valid_spacing", c - c_rel, 1000);
        check_eq("stuck_high_bcd", bcd_a, 0);
        check_eq("stuck_high_ovf", ovf_a, 0);
        @(negedge clk);
        check_eq("valid_one_cycle", mv_a, 0);
        c_prev = c;
        wait_valid(0, 1100, c);
        check_eq("valid_spacing_2", c - c_prev, 1000);
        check_eq("stuck_high_bcd_2", bcd_a, 0);

        // held low
        level = 1'b0;
        c_prev = c;
        wait_valid(0, 1100, c);
        check_eq("valid_spacing_3", c - c_prev, 1000);
        check_eq("held_low_bcd", bcd_a, 0);

        // period-10 wave: 100 edges per window
        wave_hi = 5; wave_lo = 5; t0 = cyc + 1; wave_on = 1'b1;
        wait_valid(0, 1100, c);
        wait_valid(0, 1100, c);
        check_eq("p10_bcd", bcd_a, 24'h000100);
        check_eq("p10_ovf", ovf_a, 0);
        check_eq("p10_d2_bcd", bcd_b, 8'h99);
        check_eq("p10_d2_ovf", ovf_b, 1);
        @(negedge clk);
        check_eq("p10_hold_valid", mv_a, 0);
        check_eq("p10_hold_bcd", bcd_a, 24'h000100);
        wait_valid(0, 1100, c);
        check_eq("p10_bcd_2", bcd_a, 24'h000100);

        // period-4 wave: 250 edges per window
        wave_hi = 2; wave_lo = 2; t0 = cyc + 1;
        wait_valid(0, 1100, c);
        wait_valid(0, 1100, c);
        check_eq("p4_bcd", bcd_a, 24'h000250);
        check_eq("p4_ovf", ovf_a, 0);
        check_eq("p4_d2_bcd", bcd_b, 8'h99);
        check_eq("p4_d2_ovf", ovf_b, 1);

        // back to idle low: overflow clears
        wave_on = 1'b0; level = 1'b0;
        wait_valid(0, 1100, c);
        wait_valid(0, 1100, c);
        check_eq("idle_bcd", bcd_a, 0);
        check_eq("idle_d2_bcd", bcd_b, 8'h00);
        check_eq("idle_d2_ovf", ovf_b, 0);

        // strobe on the terminal cycle: counted in the closing window
        repeat (997) @(posedge clk);
        level = 1'b1;
        wait_valid(0, 1100, c);
        w1 = int'(bcd_a);
        check_eq("term_edge_closing", bcd_a, 1);
        level = 1'b0;
        // strobe one cycle after the terminal cycle: counted in the next window
        repeat (998) @(posedge clk);
        level = 1'b1;
        wait_valid(0, 1100, c);
        w2 = int'(bcd_a);
        check_eq("late_edge_not_closing", bcd_a, 0);
        wait_valid(0, 1100, c);
        w3 = int'(bcd_a);
        check_eq("late_edge_next", bcd_a, 1);
        check_eq("edge_total_3win", w1 + w2 + w3, 2);

        // reset at gate_cnt 500 for 3 cycles
        level = 1'b0;
        repeat (500) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_bcd", bcd_a, 0);
        check_eq("midrst_ovf", ovf_a, 0);
        check_eq("midrst_gate_active", ga_a, 0);
        repeat (2) begin
            @(negedge clk);
            check_eq("midrst_no_valid", mv_a, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        c_rel = cyc;
        repeat (5) @(posedge clk);
        wave_hi = 5; wave_lo = 5; t0 = cyc + 1; wave_on = 1'b1;
        wait_valid(0, 1100, c);
        check_eq("postrst_spacing", c - c_rel, 1000);
        check_eq("postrst_bcd", bcd_a, 24'h000100);
        check_eq("postrst_ovf", ovf_a, 0);

        // period-5 wave on the 10000-cycle gate: 2000 edges, carry 1999 -> 2000
        wave_hi = 2; wave_lo = 3; t0 = cyc + 1;
        wait_valid(2, 10100, c);
        c_prev = c;
        wait_valid(2, 10100, c);
        check_eq("long_gate_spacing", c - c_prev, 10000);
        check_eq("long_gate_bcd", bcd_c, 24'h002000);
        check_eq("long_gate_ovf", ovf_c, 0);

        check_eq("no_invalid_nibble", bad_nibble, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
